// File: rtl/count_binary_switch_debounce_pkg.sv
// Shared sizing constants for the switch conditioning path.
// Production values plus the shortened debounce window used in simulation.
package count_binary_switch_debounce_pkg;

    localparam int SW_WIDTH               = 8;
    localparam int SW_DEBOUNCE_CYCLES     = 50000;  // 1 ms at 50 MHz
    localparam int SW_CNT_W               = 16;
    localparam int SW_DEBOUNCE_CYCLES_SIM = 4;

    // True when a CNT_W-bit counter can hold every value up to cycles-1.
    function automatic bit cnt_fits(input int cycles, input int cnt_w);
        return (cycles >= 2) && ((64'd1 << cnt_w) > 64'(cycles));
    endfunction

endpackage

// File: rtl/count_binary_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, accepted level and change pulse.
// accept_next is the combinational "accept this edge" term so the parent can register sw_any alongside sw_changed.
module count_binary_debounce_bit
    import count_binary_switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter int CNT_W           = SW_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic sw_out,
    output logic sw_changed,
    output logic accept_next
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // The count only ever reaches CNT_LAST while sync2 disagrees, so it never wraps.
    assign accept_next = (sync2 != sw_out) && (cnt == CNT_LAST);

    // NOTE: all state uses non-blocking assignments so sync2 sees last cycle's sync1,
    // which is what makes the two flops a real synchroniser rather than a wire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            cnt        <= '0;
            sw_out     <= 1'b0;
            sw_changed <= 1'b0;
        end else begin
            sync1      <= sw_raw;
            sync2      <= sync1;
            sw_changed <= accept_next;
            if (sync2 == sw_out) begin
                cnt <= '0;
            end else if (accept_next) begin
                cnt    <= '0;
                sw_out <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_binary_switch_debounce.sv
// Debounces the board slide switches ahead of the switch PIO: one debounce cell per bit
// plus a registered OR of the change pulses for the edge-capture/interrupt logic.
module count_binary_switch_debounce
    import count_binary_switch_debounce_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter int CNT_W           = SW_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_changed,
    output logic             sw_any
);

    logic [WIDTH-1:0] accept_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        count_binary_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk        (clk),
            .reset_n    (reset_n),
            .sw_raw     (sw_raw[i]),
            .sw_out     (sw_out[i]),
            .sw_changed (sw_changed[i]),
            .accept_next(accept_next[i])
        );
    end

    // Built from the per-bit accept terms so sw_any rises on the same edge as sw_changed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_any <= 1'b0;
        end else begin
            sw_any <= |accept_next;
        end
    end

endmodule

// File: tb/tb_count_binary_switch_debounce.sv
// Self-checking bench for count_binary_switch_debounce with a 4-cycle debounce window.
// Expected outputs are queued as stimulus is applied and compared one per clock.
module tb_count_binary_switch_debounce;

    localparam int W   = 8;
    localparam int DC  = 4;
    localparam int CW  = 3;
    localparam int LAT = DC + 2;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] chg;
        logic         any;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_out;
    logic [W-1:0] sw_changed;
    logic         sw_any;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    count_binary_switch_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw_raw    (sw_raw),
        .sw_out    (sw_out),
        .sw_changed(sw_changed),
        .sw_any    (sw_any)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] out, input logic [W-1:0] chg, input logic any);
        exp_t e;
        e.out = out;
        e.chg = chg;
        e.any = any;
        sb.push_back(e);
    endtask

    // A clean transition old->new seen on the next edge: LAT-1 idle edges, the accept edge, one settled edge.
    task automatic push_accept(input logic [W-1:0] old_v, input logic [W-1:0] new_v);
        for (int k = 1; k < LAT; k++) push(old_v, '0, 1'b0);
        push(new_v, old_v ^ new_v, 1'b1);
        push(new_v, '0, 1'b0);
    endtask

    task automatic do_reset_quiet();
        reset_n = 1'b0;
        sw_raw  = '0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n = 1'b0;
        sw_raw  = 8'hFF;
        for (int k = 0; k < 3; k++) push(8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({sw_out, sw_changed, sw_any} !== e) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got out=%h chg=%h any=%b want out=%h chg=%h any=%b",
                         k, sw_out, sw_changed, sw_any, e.out, e.chg, e.any);
            end
        end
        reset_n = 1'b1;
        push_accept(8'h00, 8'hFF);
        for (int k = 0; k < LAT + 1; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({sw_out, sw_changed, sw_any} !== e) begin
                errors++;
                $display("FAIL reset_release cyc%0d: got out=%h chg=%h any=%b want out=%h chg=%h any=%b",
                         k + 1, sw_out, sw_changed, sw_any, e.out, e.chg, e.any);
            end
        end
    endtask

    task automatic test_clean_bit2();
        exp_t e;
        do_reset_quiet();
        sw_raw = 8'h04;
        push_accept(8'h00, 8'h04);
        for (int k = 0; k < LAT + 1; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({sw_out, sw_changed, sw_any} !== e) begin
                errors++;
                $display("FAIL clean_bit2 cyc%0d: got out=%h chg=%h any=%b want out=%h chg=%h any=%b",
                         k + 1, sw_out, sw_changed, sw_any, e.out, e.chg, e.any);
            end
        end
    endtask

    // Starts from sw_out=04; bit 0 bounces in 2-cycle runs, bit 2 must be left alone.
    task automatic test_bounce_bit0();
        exp_t         e;
        logic [W-1:0] pat [8];
        pat = '{8'h05, 8'h05, 8'h04, 8'h04, 8'h05, 8'h05, 8'h04, 8'h04};
        for (int k = 0; k < 8; k++) push(8'h04, 8'h00, 1'b0);
        push_accept(8'h04, 8'h05);
        for (int k = 0; k < 8 + LAT + 1; k++) begin
            sw_raw = (k < 8) ? pat[k] : 8'h05;
            tick();
            e = sb.pop_front();
            checks++;
            if ({sw_out, sw_changed, sw_any} !== e) begin
                errors++;
                $display("FAIL bounce_bit0 cyc%0d: got out=%h chg=%h any=%b want out=%h chg=%h any=%b",
                         k + 1, sw_out, sw_changed, sw_any, e.out, e.chg, e.any);
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        do_reset_quiet();
        for (int k = 0; k < 10; k++) push(8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            sw_raw = (k == 0) ? 8'h80 : 8'h00;
            tick();
            e = sb.pop_front();
            checks++;
            if ({sw_out, sw_changed, sw_any} !== e) begin
                errors++;
                $display("FAIL glitch cyc%0d: got out=%h chg=%h any=%b want out=%h chg=%h any=%b",
                         k + 1, sw_out, sw_changed, sw_any, e.out, e.chg, e.any);
            end
        end
    endtask

    task automatic test_back_to_back_bits();
        exp_t e;
        sw_raw = 8'h22;
        push_accept(8'h00, 8'h22);
        for (int k = 0; k < LAT + 1; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({sw_out, sw_changed, sw_any} !== e) begin
                errors++;
                $display("FAIL same_edge_1_5 cyc%0d: got out=%h chg=%h any=%b want out=%h chg=%h any=%b",
                         k + 1, sw_out, sw_changed, sw_any, e.out, e.chg, e.any);
            end
        end
    endtask

    // Begins with sw_out=22 so an asynchronous clear is visible before the next edge.
    task automatic test_reset_mid_count();
        exp_t e;
        reset_n = 1'b0;
        sw_raw  = 8'h00;
        push(8'h00, 8'h00, 1'b0);
        #2;
        e = sb.pop_front();
        checks++;
        if ({sw_out, sw_changed, sw_any} !== e) begin
            errors++;
            $display("FAIL async_clear: got out=%h chg=%h any=%b want out=%h chg=%h any=%b",
                     sw_out, sw_changed, sw_any, e.out, e.chg, e.any);
        end
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();

        sw_raw = 8'h08;
        for (int k = 0; k < 4; k++) push(8'h00, 8'h00, 1'b0);
        push_accept(8'h00, 8'h08);
        for (int k = 0; k < 4 + LAT + 1; k++) begin
            if (k == 2) reset_n = 1'b0;
            if (k == 4) reset_n = 1'b1;
            tick();
            e = sb.pop_front();
            checks++;
            if ({sw_out, sw_changed, sw_any} !== e) begin
                errors++;
                $display("FAIL reset_mid_count cyc%0d: got out=%h chg=%h any=%b want out=%h chg=%h any=%b",
                         k + 1, sw_out, sw_changed, sw_any, e.out, e.chg, e.any);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries want 0", sb.size());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        sw_raw  = '0;
        test_reset();
        test_clean_bit2();
        test_bounce_bit0();
        test_glitch();
        test_back_to_back_bits();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
